// File: rtl/clause_bcp_engine.sv
// clause_bcp_engine
// Clause store plus sequential Boolean constraint propagation. Evaluates one
// clause slot per cycle, committing unit implications immediately, and
// repeats full passes until a pass makes no change or a clause conflicts.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wr_i, clause_i,
//   clause_len_i, clear_i     clause-slot write / invalidate (IDLE only)
//   start_i, cur_lvl_i,
//   var_value_i, var_lvl_i    run launch with initial assignment and levels
//   var_value_o, var_lvl_o    working assignment / levels
//   busy_o, done_o            run in progress / one-cycle completion pulse
//   conflict_o,
//   conflict_idx_o            conflict flag and conflicting slot
//   imp_count_o               number of implications in the last run
//   learntc_insert_index_o,
//   full_o                    one-hot lowest empty slot / no empty slot
module clause_bcp_engine #(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_LVL   = 16,
    parameter int unsigned WIDTH_C_LEN = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLAUSES-1:0]            wr_i,
    input  logic [2*NUM_VARS-1:0]             clause_i,
    input  logic [WIDTH_C_LEN-1:0]            clause_len_i,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [WIDTH_LVL-1:0]              cur_lvl_i,
    input  logic [3*NUM_VARS-1:0]             var_value_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0]     var_lvl_i,
    output logic [3*NUM_VARS-1:0]             var_value_o,
    output logic [NUM_VARS*WIDTH_LVL-1:0]     var_lvl_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              conflict_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]    conflict_idx_o,
    output logic [$clog2(NUM_VARS+1)-1:0]     imp_count_o,
    output logic [NUM_CLAUSES-1:0]            learntc_insert_index_o,
    output logic                              full_o
);

    localparam int unsigned CIW = $clog2(NUM_CLAUSES);
    localparam int unsigned ICW = $clog2(NUM_VARS + 1);
    localparam int unsigned VIW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [CIW-1:0] K_LAST = CIW'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [2*NUM_VARS-1:0]           cls_q [NUM_CLAUSES];
    logic [2*NUM_VARS-1:0]           cls_d [NUM_CLAUSES];
    logic [WIDTH_C_LEN-1:0]          len_q [NUM_CLAUSES];
    logic [WIDTH_C_LEN-1:0]          len_d [NUM_CLAUSES];
    logic [3*NUM_VARS-1:0]           val_q, val_d;
    logic [NUM_VARS*WIDTH_LVL-1:0]   lvl_q, lvl_d;
    logic [CIW-1:0]                  k_q, k_d;
    logic                            changed_q, changed_d;
    logic                            conflict_q, conflict_d;
    logic [CIW-1:0]                  conf_idx_q, conf_idx_d;
    logic [ICW-1:0]                  imp_q, imp_d;

    // Literal classification of the slot under evaluation
    logic [2*NUM_VARS-1:0] cur_cls;
    logic [NUM_VARS-1:0]   lit_pos, lit_neg, var_t, var_f, lit_true, lit_free;
    logic [VIW-1:0]        free_idx;
    logic                  any_true, no_free, one_free, free_pos;

    assign cur_cls = cls_q[k_q];

    for (genvar v = 0; v < NUM_VARS; v++) begin : g_lit
        assign lit_pos[v]  = (cur_cls[2*v +: 2] == 2'b01);
        assign lit_neg[v]  = (cur_cls[2*v +: 2] == 2'b10);
        assign var_t[v]    = (val_q[3*v +: 2] == 2'b01);
        assign var_f[v]    = (val_q[3*v +: 2] == 2'b10);
        assign lit_true[v] = (lit_pos[v] & var_t[v]) | (lit_neg[v] & var_f[v]);
        assign lit_free[v] = (lit_pos[v] | lit_neg[v]) & ~var_t[v] & ~var_f[v];
    end

    assign any_true = |lit_true;
    assign no_free  = (lit_free == '0);
    // Power-of-two test: exactly one free literal
    assign one_free = !no_free && ((lit_free & (lit_free - NUM_VARS'(1))) == '0);

    always_comb begin
        free_idx = '0;
        for (int v = 0; v < int'(NUM_VARS); v++) begin
            if (lit_free[v]) free_idx = VIW'(v);
        end
    end

    assign free_pos = lit_pos[free_idx];

    // Lowest empty slot, one-hot; zero when every slot is occupied
    always_comb begin
        learntc_insert_index_o = '0;
        for (int i = int'(NUM_CLAUSES) - 1; i >= 0; i--) begin
            if (len_q[i] == '0) begin
                learntc_insert_index_o    = '0;
                learntc_insert_index_o[i] = 1'b1;
            end
        end
    end

    assign full_o = (learntc_insert_index_o == '0);

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        len_d      = len_q;
        val_d      = val_q;
        lvl_d      = lvl_q;
        k_d        = k_q;
        changed_d  = changed_q;
        conflict_d = conflict_q;
        conf_idx_d = conf_idx_q;
        imp_d      = imp_q;

        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    for (int i = 0; i < int'(NUM_CLAUSES); i++) len_d[i] = '0;
                end else begin
                    for (int i = 0; i < int'(NUM_CLAUSES); i++) begin
                        if (wr_i[i]) begin
                            cls_d[i] = clause_i;
                            len_d[i] = clause_len_i;
                        end
                    end
                end
                if (start_i) begin
                    val_d      = var_value_i;
                    lvl_d      = var_lvl_i;
                    imp_d      = '0;
                    conflict_d = 1'b0;
                    conf_idx_d = '0;
                    k_d        = '0;
                    changed_d  = 1'b0;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                if ((len_q[k_q] != '0) && !any_true) begin
                    if (no_free) begin
                        conflict_d = 1'b1;
                        conf_idx_d = k_q;
                        state_d    = DONE;
                    end else if (one_free) begin
                        val_d[3*free_idx +: 3]                 = {1'b1, free_pos ? 2'b01 : 2'b10};
                        lvl_d[WIDTH_LVL*free_idx +: WIDTH_LVL] = cur_lvl_i;
                        changed_d                              = 1'b1;
                        imp_d                                  = imp_q + ICW'(1);
                    end
                end
                if (state_d == SCAN) begin
                    if (k_q == K_LAST) begin
                        // A pass that implied anything (including this slot) reruns
                        k_d = '0;
                        if (changed_d) changed_d = 1'b0;
                        else           state_d   = DONE;
                    end else begin
                        k_d = k_q + CIW'(1);
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cls_q      <= '{default: '0};
            len_q      <= '{default: '0};
            val_q      <= '0;
            lvl_q      <= '0;
            k_q        <= '0;
            changed_q  <= 1'b0;
            conflict_q <= 1'b0;
            conf_idx_q <= '0;
            imp_q      <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            len_q      <= len_d;
            val_q      <= val_d;
            lvl_q      <= lvl_d;
            k_q        <= k_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
            conf_idx_q <= conf_idx_d;
            imp_q      <= imp_d;
        end
    end

    assign var_value_o    = val_q;
    assign var_lvl_o      = lvl_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign conflict_o     = conflict_q;
    assign conflict_idx_o = conf_idx_q;
    assign imp_count_o    = imp_q;

endmodule

// File: tb/tb_clause_bcp_engine.sv
// Scoreboarded bench for clause_bcp_engine: directed clause sets and runs,
// expected run results queued at start and checked when done_o pulses.
module tb_clause_bcp_engine;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int WL  = 16;
    localparam int WCL = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NC-1:0]       wr_i = '0;
    logic [2*NV-1:0]     clause_i = '0;
    logic [WCL-1:0]      clause_len_i = '0;
    logic                clear_i = 1'b0;
    logic                start_i = 1'b0;
    logic [WL-1:0]       cur_lvl_i = '0;
    logic [3*NV-1:0]     var_value_i = '0;
    logic [NV*WL-1:0]    var_lvl_i = '0;
    logic [3*NV-1:0]     var_value_o;
    logic [NV*WL-1:0]    var_lvl_o;
    logic                busy_o, done_o, conflict_o, full_o;
    logic [2:0]          conflict_idx_o;
    logic [3:0]          imp_count_o;
    logic [NC-1:0]       learntc_insert_index_o;

    clause_bcp_engine #(
        .NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_C_LEN(WCL)
    ) dut (
        .clk(clk), .rst(rst), .wr_i(wr_i), .clause_i(clause_i),
        .clause_len_i(clause_len_i), .clear_i(clear_i), .start_i(start_i),
        .cur_lvl_i(cur_lvl_i), .var_value_i(var_value_i), .var_lvl_i(var_lvl_i),
        .var_value_o(var_value_o), .var_lvl_o(var_lvl_o), .busy_o(busy_o),
        .done_o(done_o), .conflict_o(conflict_o), .conflict_idx_o(conflict_idx_o),
        .imp_count_o(imp_count_o), .learntc_insert_index_o(learntc_insert_index_o),
        .full_o(full_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int           e0;
        int           lat;
        logic         conf;
        logic [2:0]   idx;
        logic [3:0]   imp;
        logic [23:0]  val;
        logic [127:0] lvl;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d required no completion", cyc);
            end else begin
                e = sb.pop_front();
                check("latency",      128'(cyc - e.e0),     128'(e.lat));
                check("conflict",     128'(conflict_o),     128'(e.conf));
                check("conflict_idx", 128'(conflict_idx_o), 128'(e.idx));
                check("imp_count",    128'(imp_count_o),    128'(e.imp));
                check("var_value",    128'(var_value_o),    128'(e.val));
                check("var_lvl",      var_lvl_o,            e.lvl);
            end
        end
    end

    task automatic write_slot(input int idx, input logic [15:0] c, input logic [3:0] len);
        @(negedge clk);
        wr_i         = '0;
        wr_i[idx]    = 1'b1;
        clause_i     = c;
        clause_len_i = len;
        @(negedge clk);
        wr_i = '0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] v, input logic [127:0] l, input logic [15:0] cur,
                             input bit push, input int lat, input logic conf, input logic [2:0] idx,
                             input logic [3:0] imp, input logic [23:0] ev, input logic [127:0] el);
        exp_t e;
        @(negedge clk);
        var_value_i = v;
        var_lvl_i   = l;
        cur_lvl_i   = cur;
        start_i     = 1'b1;
        if (push) begin
            e.e0 = cyc + 1; e.lat = lat; e.conf = conf; e.idx = idx;
            e.imp = imp; e.val = ev; e.lvl = el;
            sb.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            n_checks++;
            $display("FAIL run_timeout: busy_o=1 after 200 cycles, required 0");
        end
    endtask

    // Clause encodings: two bits per var, 01 positive, 10 negative
    localparam logic [15:0] C_NX0_X2   = 16'h0012;  // (~x0 | x2)
    localparam logic [15:0] C_NX2_X3   = 16'h0060;  // (~x2 | x3)
    localparam logic [15:0] C_NX0_X1   = 16'h0006;  // (~x0 | x1)
    localparam logic [15:0] C_NX0_NX1  = 16'h000A;  // (~x0 | ~x1)
    localparam logic [15:0] C_X0       = 16'h0001;  // (x0)
    localparam logic [15:0] C_NX0      = 16'h0002;  // (~x0)

    localparam logic [23:0]  V_X0T   = 24'h000001;            // x0 true, decision
    localparam logic [127:0] L_X0L1  = 128'h1;                // x0 at level 1
    localparam logic [23:0]  EV_S2   = 24'h000B41;            // x0 true, x2/x3 implied true
    localparam logic [127:0] EL_S2   = 128'h0002_0002_0000_0001;
    localparam logic [23:0]  EV_S4   = 24'h000029;            // x0 true, x1 implied true
    localparam logic [127:0] EL_S4   = 128'h0002_0001;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy",   128'(busy_o), 128'(0));
        check("rst_done",   128'(done_o), 128'(0));
        check("rst_conf",   128'(conflict_o), 128'(0));
        check("rst_imp",    128'(imp_count_o), 128'(0));
        check("rst_val",    128'(var_value_o), 128'(0));
        check("rst_index",  128'(learntc_insert_index_o), 128'(8'b0000_0001));
        check("rst_full",   128'(full_o), 128'(0));

        // Slot occupancy tracking
        for (int i = 0; i < 5; i++) write_slot(i, 16'h0005, 4'd2);
        check("ins_5used",  128'(learntc_insert_index_o), 128'(8'b0010_0000));
        check("full_5used", 128'(full_o), 128'(0));
        for (int i = 5; i < 8; i++) write_slot(i, 16'h0005, 4'd2);
        check("ins_full",   128'(learntc_insert_index_o), 128'(0));
        check("full_full",  128'(full_o), 128'(1));
        do_clear();
        check("ins_clear",  128'(learntc_insert_index_o), 128'(8'b0000_0001));
        check("full_clear", 128'(full_o), 128'(0));

        // Two-pass chain x0 -> x2 -> x3
        write_slot(0, C_NX0_X2, 4'd2);
        write_slot(1, C_NX2_X3, 4'd2);
        start_run(V_X0T, L_X0L1, 16'd2, 1'b1, 16, 1'b0, 3'd0, 4'd2, EV_S2, EL_S2);
        wait_idle();

        // Swapped order needs three passes
        write_slot(0, C_NX2_X3, 4'd2);
        write_slot(1, C_NX0_X2, 4'd2);
        start_run(V_X0T, L_X0L1, 16'd2, 1'b1, 24, 1'b0, 3'd0, 4'd2, EV_S2, EL_S2);
        wait_idle();

        // Implication then conflict in the same pass
        write_slot(0, C_NX0_X1, 4'd2);
        write_slot(1, C_NX0_NX1, 4'd2);
        start_run(V_X0T, L_X0L1, 16'd2, 1'b1, 2, 1'b1, 3'd1, 4'd1, EV_S4, EL_S4);
        wait_idle();

        // Writes and starts while busy are ignored
        write_slot(0, C_NX0_X2, 4'd2);
        write_slot(1, C_NX2_X3, 4'd2);
        write_slot(2, C_X0, 4'd1);
        check("ins_pre_busy", 128'(learntc_insert_index_o), 128'(8'b0000_1000));
        start_run(V_X0T, L_X0L1, 16'd2, 1'b1, 16, 1'b0, 3'd0, 4'd2, EV_S2, EL_S2);
        repeat (2) @(negedge clk);
        start_i      = 1'b1;
        var_value_i  = '0;
        wr_i         = 8'h08;
        clause_i     = C_NX0;
        clause_len_i = 4'd1;
        @(negedge clk);
        start_i = 1'b0;
        wr_i    = '0;
        wait_idle();
        check("ins_post_busy", 128'(learntc_insert_index_o), 128'(8'b0000_1000));

        // Reset during the second pass
        start_run(V_X0T, L_X0L1, 16'd2, 1'b0, 0, 1'b0, 3'd0, 4'd0, 24'h0, 128'h0);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 128'(busy_o), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("mrst_busy",  128'(busy_o), 128'(0));
        check("mrst_done",  128'(done_o), 128'(0));
        check("mrst_conf",  128'(conflict_o), 128'(0));
        check("mrst_imp",   128'(imp_count_o), 128'(0));
        check("mrst_val",   128'(var_value_o), 128'(0));
        check("mrst_lvl",   var_lvl_o, 128'(0));
        check("mrst_index", 128'(learntc_insert_index_o), 128'(8'b0000_0001));
        check("mrst_full",  128'(full_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        write_slot(0, C_NX0_X2, 4'd2);
        write_slot(1, C_NX2_X3, 4'd2);
        start_run(V_X0T, L_X0L1, 16'd2, 1'b1, 16, 1'b0, 3'd0, 4'd2, EV_S2, EL_S2);
        wait_idle();

        repeat (2) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
